// File: rtl/ripple_count_monitor.sv
// ----------------------------------------------------------------------------
// ripple_count_monitor
//
// Samples a free-running ripple counter that is asynchronous to clk, filters
// out samples taken while its bits are still settling, and extends the count
// to EXT_W bits by counting wraps of the narrow input in a high field. Also
// provides an overflow flag for the wrap count and a match interrupt.
//
// Ports:
//   clk        : single clock, rising edge
//   rst        : asynchronous active-low reset
//   cnt_in     : ripple counter value (async, bits may be skewed)
//   clr        : synchronous clear of extended count and all flags
//   match_en   : enables match detection
//   match_val  : compare value for the extended count
//   irq_ack    : clears irq (a simultaneous new match wins)
//   ext_cnt    : {wrap count, accepted low count}
//   cnt_valid  : a baseline has been accepted since reset/clr
//   wrap_pulse : one-cycle pulse per detected wrap of cnt_in
//   ovf        : sticky, set when the wrap count rolls over
//   irq        : level interrupt on match
// ----------------------------------------------------------------------------
module ripple_count_monitor #(
    parameter int CNT_W = 4,
    parameter int EXT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             clr,
    input  logic             match_en,
    input  logic [EXT_W-1:0] match_val,
    input  logic             irq_ack,
    output logic [EXT_W-1:0] ext_cnt,
    output logic             cnt_valid,
    output logic             wrap_pulse,
    output logic             ovf,
    output logic             irq
);

    localparam int HI_W = EXT_W - CNT_W;
    localparam logic [HI_W-1:0] HI_ONE = HI_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Synchronizer / settle-filter pipeline
    logic [CNT_W-1:0] s1_q, s2_q, s3_q;
    // Marks which stages hold a real post-reset sample, so the all-zero
    // reset contents of s2/s3 are never mistaken for a stable input.
    logic [2:0]       fill_q;
    logic             accept;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] lo_q, lo_d;
    logic [HI_W-1:0]  hi_q, hi_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             irq_q, irq_d;
    logic [EXT_W-1:0] ext_next;
    logic             irq_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            fill_q <= '0;
        end else begin
            s1_q   <= cnt_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            fill_q <= {fill_q[1:0], 1'b1};
        end
    end

    // Two consecutive equal synchronized samples mean the counter was settled.
    assign accept = fill_q[2] && (s2_q == s3_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        wrap_d   = 1'b0;
        ovf_d    = ovf_q;
        irq_d    = irq_q;
        ext_next = {hi_q, lo_q};
        irq_set  = 1'b0;

        if (clr) begin
            // clr beats any accept on the same edge; the pipeline keeps
            // running so the pending value is re-evaluated next edge.
            state_d = IDLE;
            lo_d    = '0;
            hi_d    = '0;
            ovf_d   = 1'b0;
            irq_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        lo_d    = s2_q;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (accept && (s2_q != lo_q)) begin
                        lo_d = s2_q;
                        // Input advances by less than half the range between
                        // accepts, so a smaller value can only be a wrap.
                        if (s2_q < lo_q) begin
                            hi_d   = hi_q + HI_ONE;
                            wrap_d = 1'b1;
                            if (&hi_q) begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // Only a real change of ext_cnt may raise irq; a new match has
            // priority over an acknowledge on the same edge.
            ext_next = {hi_d, lo_d};
            irq_set  = match_en && (ext_next != ext_cnt) && (ext_next == match_val);
            irq_d    = irq_set || (irq_q && !irq_ack);
        end
    end

    assign ext_cnt    = {hi_q, lo_q};
    assign cnt_valid  = (state_q == TRACK);
    assign wrap_pulse = wrap_q;
    assign ovf        = ovf_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// ----------------------------------------------------------------------------
// tb_ripple_count_monitor
//
// Directed stimulus with a behavioural model of the accepted count, wrap
// counter and flags, compared against the DUT every cycle, plus literal
// expectations at the key points of each scenario.
// ----------------------------------------------------------------------------
module tb_ripple_count_monitor;

    localparam int CNT_W = 4;
    localparam int EXT_W = 8;

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic [CNT_W-1:0] cnt_in    = '0;
    logic             clr       = 1'b0;
    logic             match_en  = 1'b0;
    logic [EXT_W-1:0] match_val = '0;
    logic             irq_ack   = 1'b0;
    logic [EXT_W-1:0] ext_cnt;
    logic             cnt_valid;
    logic             wrap_pulse;
    logic             ovf;
    logic             irq;

    int checks = 0;
    int passes = 0;
    int wraps  = 0;

    ripple_count_monitor #(.CNT_W(CNT_W), .EXT_W(EXT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .clr        (clr),
        .match_en   (match_en),
        .match_val  (match_val),
        .irq_ack    (irq_ack),
        .ext_cnt    (ext_cnt),
        .cnt_valid  (cnt_valid),
        .wrap_pulse (wrap_pulse),
        .ovf        (ovf),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Keeps the last three values seen at clock edges; a value counts once it
    // was seen on two edges in a row and both of those lie two edges back.
    int q_hist[$];
    bit m_valid = 0;
    int m_low   = 0;
    int m_high  = 0;
    bit m_wrap  = 0;
    bit m_ovf   = 0;
    bit m_irq   = 0;

    always @(posedge clk or negedge rst) begin
        int old_ext;
        int new_ext;
        int b;
        bit acc;
        if (!rst) begin
            q_hist.delete();
            m_valid = 0; m_low = 0; m_high = 0;
            m_wrap = 0; m_ovf = 0; m_irq = 0;
        end else begin
            acc = 0;
            b = 0;
            if (q_hist.size() >= 3) begin
                acc = (q_hist[q_hist.size()-2] == q_hist[q_hist.size()-3]);
                b   = q_hist[q_hist.size()-2];
            end
            old_ext = m_high * 16 + m_low;
            m_wrap = 0;
            if (clr) begin
                m_valid = 0; m_low = 0; m_high = 0; m_ovf = 0; m_irq = 0;
            end else begin
                if (acc) begin
                    if (!m_valid) begin
                        m_valid = 1;
                        m_low = b;
                    end else if (b != m_low) begin
                        if (b < m_low) begin
                            m_wrap = 1;
                            if (m_high == 15) m_ovf = 1;
                            m_high = (m_high + 1) % 16;
                        end
                        m_low = b;
                    end
                end
                new_ext = m_high * 16 + m_low;
                if (match_en && new_ext != old_ext && new_ext == int'(match_val)) m_irq = 1;
                else if (irq_ack) m_irq = 0;
            end
            q_hist.push_back(int'(cnt_in));
            while (q_hist.size() > 3) void'(q_hist.pop_front());
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("ext_cnt",    ext_cnt,    m_high * 16 + m_low);
            chk("cnt_valid",  cnt_valid,  m_valid);
            chk("wrap_pulse", wrap_pulse, m_wrap);
            chk("ovf",        ovf,        m_ovf);
            chk("irq",        irq,        m_irq);
            if (wrap_pulse === 1'b1) wraps++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic hold(input int val, input int n);
        cnt_in = val[CNT_W-1:0];
        tick(n);
    endtask

    initial begin
        int base;
        int v;
        int w;
        int mv;
        int it;
        int t;

        // Hold 5 from reset release
        cnt_in = 4'd5;
        tick(2);
        rst = 1'b1;
        base = wraps;
        tick(3);
        chk("valid_before_e4", cnt_valid, 1'b0);
        tick(1);
        chk("valid_e4", cnt_valid, 1'b1);
        chk("ext_e4", ext_cnt, 8'h05);
        tick(4);
        chk("no_wrap_hold5", wraps - base, 0);
        $display("txn hold5: ext_cnt=%02h cnt_valid=%0b", ext_cnt, cnt_valid);

        // 14 -> 15 -> 0 -> 1
        base = wraps;
        hold(14, 6); chk("ext_0e", ext_cnt, 8'h0E);
        hold(15, 6); chk("ext_0f", ext_cnt, 8'h0F);
        hold(0, 6);  chk("ext_10", ext_cnt, 8'h10);
        hold(1, 6);  chk("ext_11", ext_cnt, 8'h11);
        chk("one_wrap", wraps - base, 1);
        $display("txn wrap_seq: ext_cnt=%02h wraps=%0d", ext_cnt, wraps - base);

        // Clear, then unstable toggling 3/12, then hold 4
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_ext", ext_cnt, 8'h00);
        chk("clr_valid", cnt_valid, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cnt_in = (i % 2) ? 4'd12 : 4'd3;
            tick(1);
            chk("no_unstable_low", (ext_cnt[3:0] == 4'd3) || (ext_cnt[3:0] == 4'd12), 1'b0);
        end
        hold(4, 6);
        chk("settle_04", ext_cnt, 8'h04);
        $display("txn toggle: ext_cnt=%02h", ext_cnt);

        // Match interrupt at 0x12 with simultaneous ack
        hold(10, 6);
        hold(0, 6);
        chk("ext_10b", ext_cnt, 8'h10);
        match_en  = 1'b1;
        match_val = 8'h12;
        cnt_in    = 4'd2;
        irq_ack   = 1'b1;
        t = 0;
        while (ext_cnt != 8'h12 && t < 12) begin
            tick(1);
            t++;
        end
        chk("match_latency", t, 4);
        chk("irq_set_wins", irq, 1'b1);
        irq_ack = 1'b0;
        tick(2);
        chk("irq_held", irq, 1'b1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("irq_acked", irq, 1'b0);
        // Changing only the match controls must not raise irq
        match_en = 1'b0;
        tick(1);
        match_en = 1'b1;
        match_val = 8'h13;
        tick(1);
        match_val = 8'h12;
        tick(2);
        chk("no_irq_ctrl_change", irq, 1'b0);
        match_en = 1'b0;
        $display("txn match: ext_cnt=%02h irq=%0b", ext_cnt, irq);

        // Drive wrap count to 15, then wrap once more
        v = 2;
        it = 0;
        while (m_high != 15 && it < 200) begin
            v = (v + 6) % 16;
            hold(v, 4);
            it++;
        end
        chk("hi_15", ext_cnt[7:4], 4'hF);
        chk("ovf_before", ovf, 1'b0);
        it = 0;
        while (m_high != 0 && it < 10) begin
            v = (v + 6) % 16;
            hold(v, 4);
            it++;
        end
        chk("hi_rolled", ext_cnt[7:4], 4'h0);
        chk("ovf_set", ovf, 1'b1);
        tick(3);
        chk("ovf_sticky", ovf, 1'b1);
        $display("txn ovf: ext_cnt=%02h ovf=%0b", ext_cnt, ovf);

        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr2_ext", ext_cnt, 8'h00);
        chk("clr2_valid", cnt_valid, 1'b0);
        chk("clr2_wrap", wrap_pulse, 1'b0);
        chk("clr2_ovf", ovf, 1'b0);
        chk("clr2_irq", irq, 1'b0);
        base = wraps;
        hold(v, 6);
        chk("rebase_ext", ext_cnt, v);
        chk("rebase_valid", cnt_valid, 1'b1);
        chk("rebase_no_wrap", wraps - base, 0);
        $display("txn clr_rebase: ext_cnt=%02h", ext_cnt);

        // irq pending, then asynchronous reset mid-cycle
        w  = (v + 3) % 16;
        mv = (w < v) ? (16 + w) : w;
        match_en  = 1'b1;
        match_val = mv[7:0];
        hold(w, 6);
        chk("irq_pre_rst", irq, 1'b1);
        chk("ext_pre_rst", ext_cnt, mv);
        rst = 1'b0;
        #1;
        chk("rst_ext", ext_cnt, 8'h00);
        chk("rst_valid", cnt_valid, 1'b0);
        chk("rst_wrap", wrap_pulse, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_irq", irq, 1'b0);
        match_en = 1'b0;
        tick(2);
        base = wraps;
        rst = 1'b1;
        hold(w, 6);
        chk("post_rst_ext", ext_cnt, w);
        chk("post_rst_no_wrap", wraps - base, 0);
        chk("post_rst_irq", irq, 1'b0);
        $display("txn reset: ext_cnt=%02h irq=%0b", ext_cnt, irq);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ripple_count_monitor.md
RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of the incoming ripple count.
REQ-002 SHALL have parameter EXT_W, default 8: width of the extended count, which SHALL be greater than CNT_W.
REQ-003 SHALL have clk, input, 1: the single clock; all state changes occur on the rising edge.
REQ-004 SHALL have rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have cnt_in, input, CNT_W: ripple counter output, asynchronous to clk, bits may settle at different times.
REQ-006 SHALL have clr, input, 1: synchronous clear of the extended count and all flags.
REQ-007 SHALL have match_en, input, 1: enables match detection.
REQ-008 SHALL have match_val, input, EXT_W: extended-count compare value.
REQ-009 SHALL have irq_ack, input, 1: clears irq.
REQ-010 SHALL have ext_cnt, output, EXT_W: {wrap count, accepted count}.
REQ-011 SHALL have cnt_valid, output, 1: baseline established.
REQ-012 SHALL have wrap_pulse, output, 1: one-cycle pulse on each detected wrap of the ripple count.
REQ-013 SHALL have ovf, output, 1: sticky flag, set when the wrap count rolls over.
REQ-014 SHALL have irq, output, 1: level interrupt on match.

Function
REQ-015 SHALL register cnt_in through stages s1 -> s2 -> s3 every clock, with no combinational use of cnt_in.
REQ-016 SHALL accept s2 only when s2 == s3, meaning two consecutive equal synchronized samples.
REQ-017 SHALL implement two states: IDLE (no baseline) and TRACK.
REQ-018 In IDLE, the first accept SHALL load the low field of ext_cnt, set cnt_valid, and go to TRACK, with no wrap_pulse and no high-field change.
REQ-019 In TRACK, an accept with s2 != the low field SHALL load the low field.
REQ-020 In TRACK, if the accepted value is numerically less than the previous low field, the block SHALL treat it as a wrap: increment the high field (EXT_W-CNT_W bits) and assert wrap_pulse for exactly one cycle.
REQ-021 The design SHALL assume the count advances by fewer than 2^(CNT_W-1) between accepts; faster input is out of scope.
REQ-022 When the high field increments from all-ones to zero, the block SHALL set ovf, which stays set until clr or reset.
REQ-023 Latency: if cnt_in is stable before edge k, ext_cnt SHALL show the new value after edge k+3, and a wrap_pulse caused by that value SHALL be high in the cycle after edge k+3.
REQ-024 irq SHALL set on the cycle ext_cnt updates to a value equal to match_val while match_en=1; an unchanged ext_cnt SHALL NOT re-trigger.
REQ-025 irq SHALL stay high until irq_ack=1 is sampled; if a set and irq_ack occur on the same edge, set SHALL win and irq stays 1.
REQ-026 A change of match_val or match_en alone SHALL NOT set irq.
REQ-027 clr=1 SHALL, on the next edge, zero ext_cnt, cnt_valid, wrap_pulse, ovf and irq, and return to IDLE.
REQ-028 clr SHALL leave s1-s3 running, so the next accept after clr becomes the new baseline.
REQ-029 If clr and an accept occur on the same edge, clr SHALL win, and the accept is re-evaluated on the next edge.
REQ-030 ext_cnt SHALL be held constant while cnt_in is unstable (s2 != s3).

Reset
REQ-031 rst=0 SHALL immediately force s1-s3, ext_cnt, cnt_valid, wrap_pulse, ovf and irq to 0, and the state to IDLE.
REQ-032 Deassertion of rst SHALL take effect at the next rising edge.
REQ-033 Asserting rst mid-operation SHALL discard all state, so no wrap or irq is reported from pre-reset values.

Verification
REQ-034 Hold cnt_in=5 from reset release -> cnt_valid=1 and ext_cnt=0x05 after the 4th edge; wrap_pulse never asserted.
REQ-035 Step cnt_in 14 -> 15 -> 0 -> 1, with each value held for 6 cycles -> ext_cnt follows 0x0E, 0x0F, 0x10, 0x11; one wrap_pulse, on the 0x10 update.
REQ-036 Toggle cnt_in between 3 and 12 on alternate cycles for 10 cycles, then hold 4 -> ext_cnt never shows 3 or 12, and settles to 0x04.
REQ-037 Set match_en=1 and match_val=0x12, then drive the count through 0x12 -> irq rises with ext_cnt=0x12; assert irq_ack on that same edge as a second match -> irq stays 1; a later lone irq_ack -> irq=0.
REQ-038 Force the wrap count to 15 and wrap once more -> high field 0 and ovf=1; then clr -> all outputs 0, and the next stable input re-baselines with no wrap.
REQ-039 Drop rst mid-count with irq=1 -> all outputs 0 immediately, without a clock edge.
